// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write controller.
package regfile_pkg;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first eligible requester at or above rr_ptr, modulo NREQ.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             found,
    output logic [PTR_W-1:0] winner
);

    // Walk the offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = PTR_W'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Round-robin write-port controller for the 8-entry register file, with a sequenced clear.
//   state | meaning
//   IDLE  | arbitrate requesters, one registered write per winning cycle
//   CLEAR | write zero to addresses 0..7, one per cycle, grants suppressed
module regfile_write_ctrl #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    input  logic                     clr_req,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     clr_done
);
    import regfile_pkg::*;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_e             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, winner;
    logic               found;
    logic [NREQ-1:0]    eligible, gnt_nxt;
    logic               wr_en_nxt, busy_nxt, clr_done_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic [DATA_W-1:0]  wr_data_nxt;

    // The requester granted this cycle is still holding req; mask it out.
    assign eligible = req & ~gnt;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .winner   (winner)
    );

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        gnt_nxt      = '0;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        busy_nxt     = 1'b0;
        clr_done_nxt = 1'b0;

        if (state == CLEAR && wr_addr != LAST_ADDR) begin
            busy_nxt     = 1'b1;
            wr_en_nxt    = 1'b1;
            wr_addr_nxt  = wr_addr + ADDR_W'(1);
            wr_data_nxt  = '0;
            clr_done_nxt = (wr_addr_nxt == LAST_ADDR);
        end else if (state == IDLE && clr_req) begin
            state_nxt   = CLEAR;
            busy_nxt    = 1'b1;
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = '0;
            wr_data_nxt = '0;
        end else begin
            // Last clear write also falls through here: arbitration resumes immediately.
            state_nxt = IDLE;
            if (found) begin
                wr_en_nxt       = 1'b1;
                gnt_nxt[winner] = 1'b1;
                wr_addr_nxt     = req_addr[int'(winner)*ADDR_W +: ADDR_W];
                wr_data_nxt     = req_data[int'(winner)*DATA_W +: DATA_W];
                rr_ptr_nxt      = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            gnt      <= gnt_nxt;
            wr_en    <= wr_en_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
            busy     <= busy_nxt;
            clr_done <= clr_done_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: arbitration order, masking, clear sequence, reset abort.
module tb_regfile_write_ctrl;
    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*ADDR_W-1:0] req_addr = '0;
    logic [NREQ*DATA_W-1:0] req_data = '0;
    logic                   clr_req = 1'b0;
    logic [NREQ-1:0]        gnt;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   busy;
    logic                   clr_done;

    int errors = 0;
    int checks = 0;

    // {wr_en, wr_addr, wr_data, gnt, busy, clr_done}
    logic [17:0] obs;
    assign obs = {wr_en, wr_addr, wr_data, gnt, busy, clr_done};

    regfile_write_ctrl #(
        .NREQ   (NREQ),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .clr_req  (clr_req),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .clr_done (clr_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default_reqs();
        req_addr = {3'd6, 3'd4, 3'd2, 3'd1};
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    endtask

    task automatic test_reset();
        logic [17:0] tab [5] = '{
            {1'b1, 3'd1, 8'h11, 4'b0001, 2'b00},
            {1'b1, 3'd2, 8'h22, 4'b0010, 2'b00},
            {1'b1, 3'd4, 8'h33, 4'b0100, 2'b00},
            {1'b1, 3'd6, 8'h44, 4'b1000, 2'b00},
            {1'b1, 3'd1, 8'h11, 4'b0001, 2'b00}
        };
        load_default_reqs();
        req = 4'b1111;
        clr_req = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 18'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== tab[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %h expected %h", i, obs, tab[i]);
            end
        end
        req = 4'b0000;
        step();
        checks++;
        if (obs !== {1'b0, 3'd1, 8'h11, 4'b0000, 2'b00}) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", obs, {1'b0, 3'd1, 8'h11, 4'b0000, 2'b00});
        end
    endtask

    task automatic test_single_requester();
        logic [17:0] hit  = {1'b1, 3'd5, 8'hA5, 4'b0100, 2'b00};
        logic [17:0] miss = {1'b0, 3'd5, 8'hA5, 4'b0000, 2'b00};
        req_addr = {3'd6, 3'd5, 3'd2, 3'd1};
        req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        req = 4'b0100;
        step();
        checks++;
        if (obs !== hit) begin errors++; $display("FAIL single_first: got %h expected %h", obs, hit); end
        step();
        checks++;
        if (obs !== miss) begin errors++; $display("FAIL single_masked: got %h expected %h", obs, miss); end
        step();
        checks++;
        if (obs !== hit) begin errors++; $display("FAIL single_second: got %h expected %h", obs, hit); end
        req = 4'b0000;
        step();
        checks++;
        if (obs !== miss) begin errors++; $display("FAIL single_release: got %h expected %h", obs, miss); end
    endtask

    task automatic test_clear();
        logic [17:0] e;
        load_default_reqs();
        clr_req = 1'b1;
        req = 4'b0011;
        step();
        clr_req = 1'b0;
        e = {1'b1, 3'd0, 8'h00, 4'b0000, 2'b10};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL clear_addr0: got %h expected %h", obs, e); end
        for (int a = 1; a < 8; a++) begin
            step();
            e = {1'b1, 3'(a), 8'h00, 4'b0000, 1'b1, (a == 7)};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL clear_addr%0d: got %h expected %h", a, obs, e); end
        end
        // rr_ptr is 3 here; requester 3 is idle so the search wraps to 0.
        step();
        e = {1'b1, 3'd1, 8'h11, 4'b0001, 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL clear_first_grant: got %h expected %h", obs, e); end
        step();
        e = {1'b1, 3'd2, 8'h22, 4'b0010, 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL clear_second_grant: got %h expected %h", obs, e); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_clear_retrigger();
        logic [17:0] e;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int a = 1; a < 8; a++) begin
            if (a == 4) clr_req = 1'b1;
            step();
            clr_req = 1'b0;
            e = {1'b1, 3'(a), 8'h00, 4'b0000, 1'b1, (a == 7)};
            checks++;
            if (obs !== e) begin errors++; $display("FAIL retrig_addr%0d: got %h expected %h", a, obs, e); end
        end
        e = {1'b0, 3'd7, 8'h00, 4'b0000, 2'b00};
        step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL retrig_end: got %h expected %h", obs, e); end
        step();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL retrig_no_restart: got %h expected %h", obs, e); end
    endtask

    task automatic test_reset_mid_clear();
        logic [17:0] e;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        step();
        step();
        e = {1'b1, 3'd3, 8'h00, 4'b0000, 2'b10};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL abort_at3: got %h expected %h", obs, e); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL abort_immediate: got %h expected %h", obs, 18'h0); end
        step();
        step();
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL abort_held: got %h expected %h", obs, 18'h0); end
        rst_n = 1'b1;
        load_default_reqs();
        req = 4'b1111;
        step();
        e = {1'b1, 3'd1, 8'h11, 4'b0001, 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL abort_ptr_zero: got %h expected %h", obs, e); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_wrap();
        logic [17:0] e;
        load_default_reqs();
        req = 4'b1000;
        step();
        e = {1'b1, 3'd6, 8'h44, 4'b1000, 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL wrap_grant3: got %h expected %h", obs, e); end
        req = 4'b0000;
        step();
        req = 4'b1001;
        step();
        e = {1'b1, 3'd1, 8'h11, 4'b0001, 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL wrap_to0: got %h expected %h", obs, e); end
        step();
        e = {1'b1, 3'd6, 8'h44, 4'b1000, 2'b00};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL wrap_then3: got %h expected %h", obs, e); end
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_clear();
        test_clear_retrigger();
        test_reset_mid_clear();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the eight-register register file. Shares the file's single write port among `NREQ` requesters with round-robin arbitration and drives the 3-to-8 write decoder's address and `Enable` inputs plus write data. Also provides a sequenced clear that zeroes all eight registers in eight cycles. It sits directly between the requesting datapath units and the register file/decoder pair.

## Interface
- `NREQ`, 4: number of write requesters (2..8).
- `DATA_W`, 8: register data width.
- `ADDR_W`, 3: register address width; fixed at 3 (8 registers).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  write request per requester; level, held until granted.
- `req_addr`  in  NREQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  NREQ*DATA_W  packed write data, same packing.
- `gnt`  out  NREQ  one-hot, one-cycle grant; high in the same cycle the write is presented.
- `clr_req`  in  1  single-cycle pulse: start a clear sequence.
- `wr_en`  out  1  to the decoder `Enable`.
- `wr_addr`  out  ADDR_W  to the decoder `A2..A0`.
- `wr_data`  out  DATA_W  register file write data.
- `busy`  out  1  high while clearing.
- `clr_done`  out  1  one-cycle pulse on the last clear write.

## Operation
- States: `IDLE` (arbitrate) and `CLEAR` (sequence addresses 0..7). Reset state is `IDLE`.
- `IDLE`: each cycle, form the eligible set = `req` AND NOT `gnt` (the requester granted this cycle is masked). Search from `rr_ptr` upward, modulo `NREQ`, for the first eligible requester w.
  - If w exists: next edge sets `wr_en`=1, `wr_addr`=`req_addr[w]`, `wr_data`=`req_data[w]`, `gnt`=one-hot(w), and `rr_ptr`=(w+1) mod `NREQ`.
  - If none: `wr_en`=0 and `gnt`=0; `wr_addr`/`wr_data` hold their previous values.
- Requester rule: the cycle after seeing its `gnt`, a requester deasserts `req` or presents a new address/data.
- `clr_req` in `IDLE` takes priority over every request. The next edge enters `CLEAR` with `busy`=1, `wr_en`=1, `wr_addr`=0, `wr_data`=0, and `gnt`=0.
- `CLEAR`:
  - Each edge increments `wr_addr`; `wr_en` stays 1 and `wr_data` stays 0. No grants are issued, and `clr_req` is ignored.
  - The cycle with `wr_addr`=7 has `clr_done`=1.
  - The next edge returns to `IDLE` with `busy`=0 and `wr_en` driven by that cycle's arbitration.
  - `rr_ptr` is unchanged by a clear.
- Reset (asserted at any time, including mid-clear): immediately force `IDLE`, `rr_ptr`=0, and all outputs 0. An aborted clear produces no `clr_done`.

## Timing
- Request-to-write latency: 1 cycle (`req` sampled at edge k; `wr_en`/`gnt` valid from edge k through edge k+1).
- Throughput:
  - One write per cycle when at least two requesters are active.
  - A lone continuously-requesting requester is granted every other cycle, because of the masking rule.
- Clear sequence:
  - Exactly 8 consecutive `wr_en` cycles, starting 1 cycle after `clr_req`.
  - `clr_done` coincides with the 8th.
  - The first possible grant comes in the cycle after `clr_done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `gnt`=0, `busy`=0, `clr_done`=0.

## Structure
- Package `regfile_pkg`:
  - `ADDR_W`=3 and `NUM_REGS`=8.
  - State enum {`IDLE`, `CLEAR`}.
- Sub-module `rr_arbiter`: purely combinational. Inputs are `eligible[NREQ]` and `rr_ptr`; outputs are `found` and winner index. Instantiated once.
- Top level holds the state register, `rr_ptr`, clear counter (reusing `wr_addr`), and output registers.

## Test plan
1. Reset with `req`=4'b1111 held → all outputs 0. After release, the first grant is `gnt`=4'b0001, then 0010, 0100, 1000, 0001 on consecutive cycles, with `wr_en`=1 continuously.
2. `req`=4'b0100 only, `req_addr[2]`=5, `req_data[2]`=8'hA5 → 1 cycle later `wr_en`=1, `wr_addr`=5, `wr_data`=8'hA5, `gnt`=4'b0100. If `req` is held, the next write comes 2 cycles later.
3. `clr_req` pulse together with `req`=4'b0011 → `busy`=1 for 8 cycles, `wr_addr` 0..7, `wr_data`=0, `gnt`=0. `clr_done` is high at `wr_addr`=7. The next cycle grants requester `rr_ptr` (0 if no prior grants).
4. `clr_req` pulsed again while in `CLEAR` → ignored; the sequence still ends after exactly 8 writes.
5. `rst_n` low at clear address 3 → outputs 0 immediately. No `clr_done`. After release the block is in `IDLE` with `rr_ptr`=0.
6. Requester 3 is granted, then `req`=4'b1001 → the next grant is `gnt`=4'b0001 (the pointer wrapped from 3 to 0).
